mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// mem_port_arbiter : fetch/data arbiter onto one shared memory port, with a
//                    wait timeout that parks the block in a sticky error state.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
   parameter int TIMEOUT    = 15,
   parameter int STARVE_MAX = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_valid,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_valid,
   output logic        mem_req,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        suspend,
   output logic        bus_err
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [7:0]    c_wait_last  = 8'(TIMEOUT - 1);
   localparam logic [7:0]    c_wait_one   = 8'd1;
   localparam logic [SW-1:0] c_starve_lim = SW'(STARVE_MAX);
   localparam logic [SW-1:0] c_starve_one = SW'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DATA  = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          if_valid_q, if_valid_d;
   logic          d_valid_q, d_valid_d;
   logic          bus_err_q, bus_err_d;
   logic [7:0]    wait_q, wait_d;
   logic [SW-1:0] starve_q, starve_d;

   logic w_fetch_ok, w_data_ok, w_fetch_starved;
   logic w_grant_fetch, w_grant_data, w_done;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_be_q    <= 4'd0;
         mem_addr_q  <= 32'd0;
         mem_wdata_q <= 32'd0;
         if_rdata_q  <= 32'd0;
         d_rdata_q   <= 32'd0;
         if_valid_q  <= 1'b0;
         d_valid_q   <= 1'b0;
         bus_err_q   <= 1'b0;
         wait_q      <= 8'd0;
         starve_q    <= '0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_be_q    <= mem_be_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         if_valid_q  <= if_valid_d;
         d_valid_q   <= d_valid_d;
         bus_err_q   <= bus_err_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_be_d    = mem_be_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      if_valid_d  = 1'b0;
      d_valid_d   = 1'b0;
      bus_err_d   = bus_err_q;
      wait_d      = wait_q;
      starve_d    = starve_q;

      // A requester still holding its line during its own valid cycle is ignored.
      w_fetch_ok      = if_req & ~if_valid_q;
      w_data_ok       = d_req & ~d_valid_q;
      w_fetch_starved = w_fetch_ok & (starve_q >= c_starve_lim);
      w_grant_fetch   = 1'b0;
      w_grant_data    = 1'b0;
      w_done          = mem_req_q & mem_ready;

      case (state_q)
         ST_IDLE: begin
            if (w_data_ok && !w_fetch_starved) begin
               w_grant_data = 1'b1;
               state_d      = ST_DATA;
               mem_req_d    = 1'b1;
               mem_we_d     = d_we;
               mem_be_d     = d_be;
               mem_addr_d   = d_addr;
               mem_wdata_d  = d_wdata;
               wait_d       = 8'd0;
            end else if (w_fetch_ok) begin
               w_grant_fetch = 1'b1;
               state_d       = ST_FETCH;
               mem_req_d     = 1'b1;
               mem_we_d      = 1'b0;
               mem_be_d      = 4'b1111;
               mem_addr_d    = if_addr;
               wait_d        = 8'd0;
            end
         end
         ST_FETCH, ST_DATA: begin
            if (w_done) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
               if (state_q == ST_FETCH) begin
                  if_rdata_d = mem_rdata;
                  if_valid_d = 1'b1;
               end else begin
                  d_valid_d = 1'b1;
                  if (!mem_we_q) begin
                     d_rdata_d = mem_rdata;
                  end
               end
            end else if (wait_q == c_wait_last) begin
               // Timeout: complete the pending port with zero data and lock up.
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ST_ERR;
               if (state_q == ST_FETCH) begin
                  if_rdata_d = 32'd0;
                  if_valid_d = 1'b1;
               end else begin
                  d_rdata_d = 32'd0;
                  d_valid_d = 1'b1;
               end
            end else begin
               wait_d = wait_q + c_wait_one;
            end
         end
         ST_ERR: begin
            mem_req_d = 1'b0;
            bus_err_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (!if_req || w_grant_fetch) begin
         starve_d = '0;
      end else if (w_grant_data && (starve_q < c_starve_lim)) begin
         starve_d = starve_q + c_starve_one;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_be    = mem_be_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign if_valid  = if_valid_q;
   assign d_valid   = d_valid_q;
   assign bus_err   = bus_err_q;
   assign suspend   = (if_req & ~if_valid_q) | (d_req & ~d_valid_q) | (state_q == ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter : directed and randomized checks of mem_port_arbiter
//                       against a transaction-level reference model.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;

   localparam int TIMEOUT    = 15;
   localparam int STARVE_MAX = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_valid;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        suspend;
   logic        bus_err;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: who owns the bus, what it asked for, what each port last saw.
   int          m_owner;   // 0 = nobody, 1 = fetch, 2 = data
   int          m_wait;
   int          m_streak;
   logic        m_err, m_req, m_we, m_if_valid, m_d_valid;
   logic [3:0]  m_be;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_d_rdata;

   int   cnt, n_dgrants, dly;
   logic got_fetch, prev_mreq, d_new, f_hold, d_hold;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .suspend(suspend), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=no finish required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_owner = 0; m_wait = 0; m_streak = 0;
      m_err = 0; m_req = 0; m_we = 0; m_be = 4'd0;
      m_addr = 32'd0; m_wdata = 32'd0; m_if_rdata = 32'd0; m_d_rdata = 32'd0;
      m_if_valid = 0; m_d_valid = 0;
   endtask

   // Advance the model across one clock edge using the inputs currently applied.
   task automatic predict();
      logic f_ok, d_ok, pick_f, pick_d, nv_if, nv_d;
      if (reset) begin
         model_clear();
         return;
      end
      f_ok = if_req && !m_if_valid;
      d_ok = d_req && !m_d_valid;
      pick_f = 0; pick_d = 0; nv_if = 0; nv_d = 0;
      if (m_err) begin
         nv_if = 0;
      end else if (m_owner != 0) begin
         if (mem_ready) begin
            if (m_owner == 1) begin m_if_rdata = mem_rdata; nv_if = 1; end
            else begin nv_d = 1; if (!m_we) m_d_rdata = mem_rdata; end
            m_owner = 0; m_req = 0;
         end else begin
            m_wait++;
            if (m_wait == TIMEOUT) begin
               if (m_owner == 1) begin m_if_rdata = 32'd0; nv_if = 1; end
               else begin m_d_rdata = 32'd0; nv_d = 1; end
               m_owner = 0; m_req = 0; m_err = 1;
            end
         end
      end else begin
         if (d_ok && !(f_ok && m_streak >= STARVE_MAX)) pick_d = 1;
         else if (f_ok) pick_f = 1;
         if (pick_d) begin
            m_owner = 2; m_req = 1; m_wait = 0;
            m_we = d_we; m_be = d_be; m_addr = d_addr; m_wdata = d_wdata;
         end else if (pick_f) begin
            m_owner = 1; m_req = 1; m_wait = 0;
            m_we = 0; m_be = 4'hF; m_addr = if_addr;
         end
      end
      if (!if_req || pick_f) m_streak = 0;
      else if (pick_d) m_streak = (m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1;
      m_if_valid = nv_if;
      m_d_valid  = nv_d;
   endtask

   task automatic compare();
      chk("mem_req",  32'(mem_req),  32'(m_req));
      chk("if_valid", 32'(if_valid), 32'(m_if_valid));
      chk("d_valid",  32'(d_valid),  32'(m_d_valid));
      chk("if_rdata", if_rdata, m_if_rdata);
      chk("d_rdata",  d_rdata,  m_d_rdata);
      chk("bus_err",  32'(bus_err),  32'(m_err));
      if (m_req) begin
         chk("mem_addr", mem_addr, m_addr);
         chk("mem_we",   32'(mem_we), 32'(m_we));
         chk("mem_be",   32'(mem_be), 32'(m_be));
         if (m_owner == 2) chk("mem_wdata", mem_wdata, m_wdata);
      end
   endtask

   // Caller sets inputs just after a rising edge, then calls tick.
   task automatic tick();
      #1;
      chk("suspend", 32'(suspend),
          32'((if_req & ~m_if_valid) | (d_req & ~m_d_valid) | m_err));
      predict();
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      reset = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
      d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_ready = 0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      tick();
      chk("rst_mem_addr",  mem_addr,  32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_be",    32'(mem_be), 32'd0);
      reset = 0;
      tick();

      // Single fetch, response in the first cycle after mem_req rises.
      if_req = 1; if_addr = 32'h100;
      tick();
      chk("f1_mem_addr", mem_addr, 32'h100);
      chk("f1_mem_we", 32'(mem_we), 32'd0);
      mem_ready = 1; mem_rdata = 32'h0000_0013;
      tick();
      chk("f1_if_valid", 32'(if_valid), 32'd1);
      chk("f1_if_rdata", if_rdata, 32'h13);
      if_req = 0; mem_ready = 0;
      tick();
      chk("f1_pulse_end", 32'(if_valid), 32'd0);

      // Simultaneous fetch and store: data first, fetch during d_valid.
      if_req = 1; if_addr = 32'h104;
      d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      tick();
      chk("sim_mem_we",    32'(mem_we), 32'd1);
      chk("sim_mem_be",    32'(mem_be), 32'h3);
      chk("sim_mem_addr",  mem_addr, 32'h2000);
      chk("sim_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      mem_ready = 1; mem_rdata = 32'h5555_5555;
      tick();
      chk("sim_d_valid", 32'(d_valid), 32'd1);
      chk("sim_store_rdata", d_rdata, 32'd0);
      mem_ready = 0;
      tick();
      chk("sim_fetch_req",  32'(mem_req), 32'd1);
      chk("sim_fetch_addr", mem_addr, 32'h104);
      d_req = 0; mem_ready = 1; mem_rdata = 32'h0050_0093;
      tick();
      chk("sim_if_rdata", if_rdata, 32'h0050_0093);
      if_req = 0; mem_ready = 0;
      tick();

      // Fetch held while loads keep arriving back to back.
      if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h4000; d_be = 4'hF;
      n_dgrants = 0; got_fetch = 0; prev_mreq = mem_req; d_new = 0;
      for (int i = 0; i < 30 && !got_fetch; i++) begin
         if (d_new) begin d_addr = d_addr + 32'd4; d_new = 0; end
         if (d_valid) d_new = 1;
         mem_ready = mem_req; mem_rdata = 32'hA5A5_0000 + 32'(i);
         tick();
         if (mem_req && !prev_mreq) begin
            if (mem_addr == 32'h200) got_fetch = 1;
            else n_dgrants++;
         end
         prev_mreq = mem_req;
      end
      chk("starve_fetch_granted", 32'(got_fetch), 32'd1);
      chk("starve_data_grants_le_max", 32'(n_dgrants <= STARVE_MAX), 32'd1);
      for (int i = 0; i < 40 && (if_req || d_req); i++) begin
         if (if_valid) if_req = 0;
         if (d_valid) d_req = 0;
         mem_ready = mem_req; mem_rdata = 32'hA5A5_1000 + 32'(i);
         tick();
      end
      chk("starve_drained", 32'(if_req | d_req), 32'd0);
      mem_ready = 0;
      tick();

      // Timeout on a load with mem_ready stuck low.
      d_req = 1; d_we = 0; d_addr = 32'h3000;
      tick();
      chk("to_granted", 32'(mem_req), 32'd1);
      cnt = 0;
      while (mem_req && cnt < 40) begin
         tick();
         cnt++;
      end
      chk("to_wait_cycles", 32'(cnt), 32'(TIMEOUT));
      chk("to_d_valid", 32'(d_valid), 32'd1);
      chk("to_d_rdata", d_rdata, 32'd0);
      chk("to_bus_err", 32'(bus_err), 32'd1);
      d_req = 0; if_req = 1; if_addr = 32'h500;
      for (int i = 0; i < 6; i++) begin
         mem_ready = 1'($urandom_range(0, 1));
         tick();
         chk("err_no_req", 32'(mem_req), 32'd0);
      end
      if_req = 0; reset = 1;
      tick();
      reset = 0;
      tick();
      chk("err_cleared", 32'(bus_err), 32'd0);

      // Reset in the middle of a store that has waited three cycles.
      d_req = 1; d_we = 1; d_addr = 32'h6000; d_wdata = 32'h1234_5678; d_be = 4'hF;
      mem_ready = 0;
      tick();
      repeat (3) tick();
      reset = 1; d_req = 0;
      tick();
      chk("mid_rst_req",   32'(mem_req), 32'd0);
      chk("mid_rst_err",   32'(bus_err), 32'd0);
      chk("mid_rst_valid", 32'(d_valid), 32'd0);
      reset = 0;
      tick();
      d_req = 1; d_we = 0; d_addr = 32'h7000;
      tick();
      mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
      tick();
      chk("post_rst_valid", 32'(d_valid), 32'd1);
      chk("post_rst_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 0; mem_ready = 0;
      tick();

      // Randomized traffic with a bounded-latency memory and rare resets.
      f_hold = 0; d_hold = 0; dly = 0; prev_mreq = mem_req;
      for (int c = 0; c < 1500; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if (f_hold) begin f_hold = 0; if_req = 0; end
         else if (if_valid) begin
            if ($urandom_range(0, 1) == 1) f_hold = 1; else if_req = 0;
         end else if (!if_req && $urandom_range(0, 2) == 0) begin
            if_req = 1; if_addr = $urandom;
         end
         if (d_hold) begin d_hold = 0; d_req = 0; end
         else if (d_valid) begin
            if ($urandom_range(0, 1) == 1) d_hold = 1; else d_req = 0;
         end else if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
            d_addr = $urandom; d_wdata = $urandom;
         end
         if (mem_req) begin
            if (!prev_mreq) dly = $urandom_range(0, 4);
            mem_ready = (dly == 0);
            if (dly != 0) dly--;
         end else begin
            mem_ready = 1'($urandom_range(0, 1));
         end
         mem_rdata = $urandom;
         prev_mreq = mem_req;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
